// File: rtl/medidor_pkg.sv
// Shared definitions for the HC-SR04 ranging controller: state encoding and
// default timing constants for a 50 MHz clock.
package medidor_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    TRIGGER       = 4'd2,
    ESPERA_ECO    = 4'd3,
    INICIA_MEDIDA = 4'd4,
    MEDE          = 4'd5,
    ARMAZENA      = 4'd6,
    FINAL         = 4'd7,
    ERRO          = 4'd8
  } estado_t;

  localparam int TRIG_CICLOS_PAD = 500;
  localparam int ESPERA_MAX_PAD  = 1_500_000;
  localparam int MAX_TICKS_PAD   = 400;
  localparam int N_PAD           = 12;
  // Modulus of the external tick counter giving 1 tick = 1 cm at 50 MHz.
  localparam int MODULO_TICK     = 2941;

endpackage

// File: rtl/sincronizador_2ff.sv
// Reusable 1-bit double-flop synchronizer for asynchronous inputs.
module sincronizador_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sinc_q, sinc_d;

  // Next-state of the two synchronizer stages.
  always_comb begin
    meta_d = d;
    sinc_d = meta_q;
  end

  // Synchronizer flops, cleared by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sinc_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sinc_q <= sinc_d;
    end
  end

  assign q = sinc_q;

endmodule

// File: rtl/medidor_eco_hcsr04.sv
// HC-SR04 ranging controller: issues the trigger, times the echo with an
// external tick counter and reports the distance in ticks or a timeout.
module medidor_eco_hcsr04
  import medidor_pkg::*;
#(
  parameter int TRIG_CICLOS = TRIG_CICLOS_PAD,
  parameter int ESPERA_MAX  = ESPERA_MAX_PAD,
  parameter int MAX_TICKS   = MAX_TICKS_PAD,
  parameter int N           = N_PAD
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         medir,
  input  logic         echo,
  input  logic         tick,
  output logic         trigger,
  output logic         zera_tick,
  output logic         conta_tick,
  output logic [N-1:0] medida,
  output logic         pronto,
  output logic         timeout,
  output logic         ocupado
);

  localparam int CW = 32;

  logic echo_s;
  logic sobe_s, desce_s;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] ciclos_q, ciclos_d;
  logic [N-1:0]  medida_int_q, medida_int_d;
  logic [N-1:0]  medida_q, medida_d;
  logic          echo_ant_q, echo_ant_d;
  logic          trigger_q, trigger_d;
  logic          zera_tick_q, zera_tick_d;
  logic          conta_tick_q, conta_tick_d;
  logic          pronto_q, pronto_d;
  logic          timeout_q, timeout_d;
  logic          ocupado_q, ocupado_d;

  sincronizador_2ff u_sinc_echo (
    .clock (clock),
    .reset (reset),
    .d     (echo),
    .q     (echo_s)
  );

  assign sobe_s  = echo_s & ~echo_ant_q;
  assign desce_s = ~echo_s & echo_ant_q;

  // Next state, counters and Moore outputs decoded from the next state so
  // every output is a flop that lines up with its state.
  always_comb begin
    estado_d     = estado_q;
    ciclos_d     = ciclos_q;
    medida_int_d = medida_int_q;
    medida_d     = medida_q;
    echo_ant_d   = echo_s;

    case (estado_q)
      INICIAL: begin
        if (medir) estado_d = PREPARA;
        else       estado_d = INICIAL;
      end
      PREPARA: begin
        ciclos_d     = '0;
        medida_int_d = '0;
        estado_d     = TRIGGER;
      end
      TRIGGER: begin
        if (ciclos_q == CW'(TRIG_CICLOS - 1)) begin
          ciclos_d = '0;
          estado_d = ESPERA_ECO;
        end else begin
          ciclos_d = ciclos_q + 32'd1;
        end
      end
      ESPERA_ECO: begin
        if (sobe_s) begin
          estado_d = INICIA_MEDIDA;
        end else if (ciclos_q == CW'(ESPERA_MAX - 1)) begin
          estado_d = ERRO;
        end else begin
          ciclos_d = ciclos_q + 32'd1;
        end
      end
      INICIA_MEDIDA: begin
        estado_d = MEDE;
      end
      MEDE: begin
        if (tick) medida_int_d = medida_int_q + N'(1);
        else      medida_int_d = medida_int_q;
        // A tick arriving with the echo fall still counts; hitting the
        // ceiling wins over the fall.
        if (medida_int_d == N'(MAX_TICKS)) estado_d = ERRO;
        else if (desce_s)                  estado_d = ARMAZENA;
        else                               estado_d = MEDE;
      end
      ARMAZENA: begin
        medida_d = medida_int_q;
        estado_d = FINAL;
      end
      FINAL: begin
        estado_d = INICIAL;
      end
      ERRO: begin
        estado_d = INICIAL;
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase

    trigger_d    = (estado_d == TRIGGER);
    zera_tick_d  = (estado_d == PREPARA) || (estado_d == INICIA_MEDIDA);
    conta_tick_d = (estado_d == MEDE);
    pronto_d     = (estado_d == FINAL);
    ocupado_d    = (estado_d != INICIAL);

    if (estado_d == ERRO)         timeout_d = 1'b1;
    else if (estado_d == PREPARA) timeout_d = 1'b0;
    else                          timeout_d = timeout_q;
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q     <= INICIAL;
      ciclos_q     <= '0;
      medida_int_q <= '0;
      medida_q     <= '0;
      echo_ant_q   <= 1'b0;
      trigger_q    <= 1'b0;
      zera_tick_q  <= 1'b0;
      conta_tick_q <= 1'b0;
      pronto_q     <= 1'b0;
      timeout_q    <= 1'b0;
      ocupado_q    <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      ciclos_q     <= ciclos_d;
      medida_int_q <= medida_int_d;
      medida_q     <= medida_d;
      echo_ant_q   <= echo_ant_d;
      trigger_q    <= trigger_d;
      zera_tick_q  <= zera_tick_d;
      conta_tick_q <= conta_tick_d;
      pronto_q     <= pronto_d;
      timeout_q    <= timeout_d;
      ocupado_q    <= ocupado_d;
    end
  end

  assign trigger    = trigger_q;
  assign zera_tick  = zera_tick_q;
  assign conta_tick = conta_tick_q;
  assign medida     = medida_q;
  assign pronto     = pronto_q;
  assign timeout    = timeout_q;
  assign ocupado    = ocupado_q;

endmodule

// File: tb/tb_medidor_eco_hcsr04.sv
// Self-checking bench for medidor_eco_hcsr04 with an external modulo-10 tick
// counter and an arithmetic reference for the expected distance.
module tb_medidor_eco_hcsr04;

  localparam int TRIG     = 5;
  localparam int ESPERA   = 100;
  localparam int MAXT     = 20;
  localparam int N        = 12;
  localparam int PER_TICK = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         medir = 1'b0;
  logic         echo  = 1'b0;
  logic         tick;
  logic         trigger, zera_tick, conta_tick, pronto, timeout, ocupado;
  logic [N-1:0] medida;

  int checks = 0;
  int errors = 0;
  int cnt_tick;

  int cyc, trig_len, trig_first, n_pronto, cyc_pronto, cyc_timeout;
  int cyc_trig_fall, cyc_echo_rise, cyc_echo_fall;
  logic         ocup1, zera1, timeout1;
  logic [N-1:0] med_pronto;
  logic [N-1:0] medida_ref = '0;

  medidor_eco_hcsr04 #(
    .TRIG_CICLOS (TRIG),
    .ESPERA_MAX  (ESPERA),
    .MAX_TICKS   (MAXT),
    .N           (N)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .medir      (medir),
    .echo       (echo),
    .tick       (tick),
    .trigger    (trigger),
    .zera_tick  (zera_tick),
    .conta_tick (conta_tick),
    .medida     (medida),
    .pronto     (pronto),
    .timeout    (timeout),
    .ocupado    (ocupado)
  );

  always #5 clock = ~clock;

  // External modulo-10 tick counter driven by the DUT's clear/enable.
  always @(posedge clock or posedge reset) begin
    if (reset)           cnt_tick <= 0;
    else if (zera_tick)  cnt_tick <= 0;
    else if (conta_tick) cnt_tick <= (cnt_tick == PER_TICK - 1) ? 0 : cnt_tick + 1;
  end
  assign tick = conta_tick && (cnt_tick == PER_TICK - 1);

  // Reference: one tick per full 10 cycles of the (h-1)-cycle counting window.
  function automatic int esperado(input int h);
    return (h - 1) / PER_TICK;
  endfunction

  task automatic amostra();
    cyc++;
    if (cyc == 1) begin
      ocup1 = ocupado; zera1 = zera_tick; timeout1 = timeout;
    end
    if (trigger) begin
      trig_len++;
      if (trig_first < 0) trig_first = cyc;
    end
    if (pronto) begin
      n_pronto++; cyc_pronto = cyc; med_pronto = medida;
    end
    if (timeout && cyc_timeout < 0 && cyc > 1) cyc_timeout = cyc;
  endtask

  task automatic medir_ciclo(input int d, input int h, input bit busy);
    bit visto;
    cyc = 0; trig_len = 0; trig_first = -1; n_pronto = 0; cyc_pronto = -1;
    cyc_timeout = -1; cyc_trig_fall = -1; cyc_echo_rise = -1; cyc_echo_fall = -1;
    @(negedge clock); medir = 1'b1;
    @(negedge clock); medir = 1'b0; amostra();
    visto = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock); amostra();
      if (trigger) begin
        visto = 1'b1; medir = busy;
      end else if (visto) begin
        medir = 1'b0; cyc_trig_fall = cyc; break;
      end
    end
    medir = 1'b0;
    for (int i = 0; i < d; i++) begin @(negedge clock); amostra(); end
    if (h > 0) begin
      echo = 1'b1; cyc_echo_rise = cyc;
      for (int i = 0; i < h; i++) begin @(negedge clock); amostra(); end
      echo = 1'b0; cyc_echo_fall = cyc;
    end
    for (int i = 0; i < ((h > 0) ? 30 : ESPERA + 40); i++) begin
      @(negedge clock); amostra();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; medir = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({trigger, zera_tick, conta_tick, pronto, timeout, ocupado} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs obtido=%b esperado=000000",
               {trigger, zera_tick, conta_tick, pronto, timeout, ocupado});
    end
    checks++;
    if (medida !== 12'd0) begin
      errors++; $display("FAIL reset_medida obtido=%0d esperado=0", medida);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (ocupado !== 1'b0) begin
      errors++; $display("FAIL idle_ocupado obtido=%b esperado=0", ocupado);
    end
  endtask

  task automatic test_nominal();
    medir_ciclo(20, 123, 1'b0);
    checks++;
    if (ocup1 !== 1'b1 || zera1 !== 1'b1) begin
      errors++; $display("FAIL nom_prepara ocupado=%b zera=%b esperado=1 1", ocup1, zera1);
    end
    checks++;
    if (trig_first !== 2) begin
      errors++; $display("FAIL nom_trig_start obtido=%0d esperado=2", trig_first);
    end
    checks++;
    if (trig_len !== TRIG) begin
      errors++; $display("FAIL nom_trig_len obtido=%0d esperado=%0d", trig_len, TRIG);
    end
    checks++;
    if (n_pronto !== 1 || med_pronto !== 12'(esperado(123))) begin
      errors++; $display("FAIL nom_medida pulsos=%0d medida=%0d esperado=1 %0d",
                         n_pronto, med_pronto, esperado(123));
    end
    checks++;
    if (cyc_pronto !== cyc_echo_fall + 4) begin
      errors++; $display("FAIL nom_latencia obtido=%0d esperado=%0d", cyc_pronto, cyc_echo_fall + 4);
    end
    checks++;
    if (timeout !== 1'b0 || ocupado !== 1'b0 || medida !== 12'(esperado(123))) begin
      errors++; $display("FAIL nom_final timeout=%b ocupado=%b medida=%0d esperado=0 0 %0d",
                         timeout, ocupado, medida, esperado(123));
    end
    medida_ref = 12'(esperado(123));
  endtask

  task automatic test_no_echo();
    medir_ciclo(0, 0, 1'b0);
    checks++;
    if (timeout !== 1'b1 || n_pronto !== 0) begin
      errors++; $display("FAIL noecho_flag timeout=%b pulsos=%0d esperado=1 0", timeout, n_pronto);
    end
    checks++;
    if (cyc_timeout - cyc_trig_fall !== ESPERA) begin
      errors++; $display("FAIL noecho_tempo obtido=%0d esperado=%0d", cyc_timeout - cyc_trig_fall, ESPERA);
    end
    checks++;
    if (medida !== medida_ref) begin
      errors++; $display("FAIL noecho_medida obtido=%0d esperado=%0d", medida, medida_ref);
    end
  endtask

  task automatic test_timeout_clear();
    medir_ciclo(15, 64, 1'b0);
    checks++;
    if (timeout1 !== 1'b0) begin
      errors++; $display("FAIL tclr_prepara obtido=%b esperado=0", timeout1);
    end
    checks++;
    if (n_pronto !== 1 || med_pronto !== 12'(esperado(64)) || timeout !== 1'b0) begin
      errors++; $display("FAIL tclr_medida pulsos=%0d medida=%0d timeout=%b esperado=1 %0d 0",
                         n_pronto, med_pronto, timeout, esperado(64));
    end
    medida_ref = 12'(esperado(64));
  endtask

  task automatic test_long_echo();
    medir_ciclo(10, 300, 1'b0);
    checks++;
    if (timeout !== 1'b1 || n_pronto !== 0 || medida !== medida_ref) begin
      errors++; $display("FAIL long_erro timeout=%b pulsos=%0d medida=%0d esperado=1 0 %0d",
                         timeout, n_pronto, medida, medida_ref);
    end
    checks++;
    if (cyc_timeout !== cyc_echo_rise + 4 + MAXT * PER_TICK) begin
      errors++; $display("FAIL long_tempo obtido=%0d esperado=%0d",
                         cyc_timeout, cyc_echo_rise + 4 + MAXT * PER_TICK);
    end
    // One tick short of the ceiling still completes.
    medir_ciclo(10, 200, 1'b0);
    checks++;
    if (n_pronto !== 1 || med_pronto !== 12'(MAXT - 1) || timeout !== 1'b0) begin
      errors++; $display("FAIL long_limite pulsos=%0d medida=%0d timeout=%b esperado=1 %0d 0",
                         n_pronto, med_pronto, timeout, MAXT - 1);
    end
    medida_ref = 12'(MAXT - 1);
  endtask

  task automatic test_simultaneous();
    // 101-cycle echo: the last counting cycle carries the 10th tick.
    medir_ciclo(12, 101, 1'b0);
    checks++;
    if (n_pronto !== 1 || med_pronto !== 12'd10) begin
      errors++; $display("FAIL simult pulsos=%0d medida=%0d esperado=1 10", n_pronto, med_pronto);
    end
    medida_ref = 12'd10;
  endtask

  task automatic test_busy_reset();
    bit visto, ok;
    medir_ciclo(20, 53, 1'b1);
    checks++;
    if (n_pronto !== 1 || med_pronto !== 12'(esperado(53)) || trig_len !== TRIG || ocupado !== 1'b0) begin
      errors++; $display("FAIL busy pulsos=%0d medida=%0d trig=%0d ocupado=%b esperado=1 %0d %0d 0",
                         n_pronto, med_pronto, trig_len, ocupado, esperado(53), TRIG);
    end
    @(negedge clock); medir = 1'b1;
    @(negedge clock); medir = 1'b0;
    visto = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (trigger) visto = 1'b1;
      else if (visto) break;
    end
    repeat (10) @(negedge clock);
    echo = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (conta_tick) begin ok = 1'b1; break; end
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL rst_mede_alcancado obtido=%b esperado=1", ok);
    end
    repeat (15) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({trigger, zera_tick, conta_tick, pronto, timeout, ocupado} !== 6'b0 || medida !== 12'd0) begin
      errors++; $display("FAIL rst_async saidas=%b medida=%0d esperado=000000 0",
                         {trigger, zera_tick, conta_tick, pronto, timeout, ocupado}, medida);
    end
    echo = 1'b0;
    @(negedge clock); reset = 1'b0;
    medida_ref = '0;
    medir_ciclo(10, 88, 1'b0);
    checks++;
    if (n_pronto !== 1 || med_pronto !== 12'(esperado(88)) || timeout !== 1'b0) begin
      errors++; $display("FAIL rst_retoma pulsos=%0d medida=%0d timeout=%b esperado=1 %0d 0",
                         n_pronto, med_pronto, timeout, esperado(88));
    end
    medida_ref = 12'(esperado(88));
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int d, h, e;
      d = $urandom_range(5, 80);
      h = $urandom_range(2, 260);
      if (h >= 198 && h <= 204) h = 150;
      medir_ciclo(d, h, 1'b0);
      e = esperado(h);
      checks++;
      if (e >= MAXT) begin
        if (timeout !== 1'b1 || n_pronto !== 0 || medida !== medida_ref) begin
          errors++; $display("FAIL rand_erro h=%0d timeout=%b pulsos=%0d medida=%0d esperado=1 0 %0d",
                             h, timeout, n_pronto, medida, medida_ref);
        end
      end else begin
        if (n_pronto !== 1 || med_pronto !== 12'(e) || timeout !== 1'b0) begin
          errors++; $display("FAIL rand_ok h=%0d pulsos=%0d medida=%0d timeout=%b esperado=1 %0d 0",
                             h, n_pronto, med_pronto, timeout, e);
        end
        medida_ref = 12'(e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_no_echo();
    test_timeout_clear();
    test_long_echo();
    test_simultaneous();
    test_busy_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
